// File: rtl/touch_coord_conditioner.sv
// Conditions raw touch samples (press qualification, coordinate mapping, averaging)
// and hands them to the display side only on frame boundaries.
module touch_coord_conditioner #(
    parameter int IN_W      = 12,
    parameter int OUT_XW    = 10,
    parameter int OUT_YW    = 9,
    parameter int X_OFFSET  = 150,
    parameter int Y_OFFSET  = 300,
    parameter int X_SHIFT   = 2,
    parameter int Y_SHIFT   = 2,
    parameter int X_MAX     = 479,
    parameter int Y_MAX     = 271,
    parameter int Z_PRESS   = 256,
    parameter int Z_RELEASE = 128,
    parameter int DEBOUNCE  = 4,
    parameter int AVG_LOG2  = 2
) (
    input  logic              cclk,
    input  logic              rstb,
    input  logic              sample_valid,
    input  logic [IN_W-1:0]   touch_x,
    input  logic [IN_W-1:0]   touch_y,
    input  logic [IN_W-1:0]   touch_z,
    input  logic              new_frame,
    output logic [OUT_XW-1:0] locked_x,
    output logic [OUT_YW-1:0] locked_y,
    output logic              touch_active,
    output logic              press_pulse,
    output logic              release_pulse
);

    localparam logic [IN_W:0]     XOFF   = (IN_W+1)'(X_OFFSET);
    localparam logic [IN_W:0]     YOFF   = (IN_W+1)'(Y_OFFSET);
    localparam logic [IN_W-1:0]   XMAX_I = IN_W'(X_MAX);
    localparam logic [IN_W-1:0]   YMAX_I = IN_W'(Y_MAX);
    localparam logic [OUT_XW-1:0] XMAX_O = OUT_XW'(X_MAX);
    localparam logic [OUT_YW-1:0] YMAX_O = OUT_YW'(Y_MAX);
    localparam logic [IN_W-1:0]   ZP     = IN_W'(Z_PRESS);
    localparam logic [IN_W-1:0]   ZR     = IN_W'(Z_RELEASE);
    localparam int                DW     = $clog2(DEBOUNCE + 1);
    localparam logic [DW-1:0]     DB_LAST = DW'(DEBOUNCE - 1);
    localparam int                CW     = AVG_LOG2 + 1;
    localparam logic [CW-1:0]     S_LAST = CW'((1 << AVG_LOG2) - 1);
    localparam int                AXW    = OUT_XW + AVG_LOG2;
    localparam int                AYW    = OUT_YW + AVG_LOG2;

    typedef enum logic [1:0] {IDLE, PEND_PRESS, PRESSED, PEND_REL} state_t;

    // ---------------- mapping stage ----------------
    logic [IN_W:0]     adj_x, adj_y;
    logic [IN_W-1:0]   sh_x, sh_y;
    logic [OUT_XW-1:0] map_x_d;
    logic [OUT_YW-1:0] map_y_d;

    always_comb begin
        adj_x   = {1'b0, touch_x} - XOFF;
        adj_y   = {1'b0, touch_y} - YOFF;
        // MSB of the widened difference flags an underflow below the offset
        sh_x    = adj_x[IN_W] ? '0 : (adj_x[IN_W-1:0] >> X_SHIFT);
        sh_y    = adj_y[IN_W] ? '0 : (adj_y[IN_W-1:0] >> Y_SHIFT);
        map_x_d = (sh_x > XMAX_I) ? XMAX_O : sh_x[OUT_XW-1:0];
        map_y_d = (sh_y > YMAX_I) ? YMAX_O : sh_y[OUT_YW-1:0];
    end

    logic              map_valid, map_hi, map_lo;
    logic [OUT_XW-1:0] map_x;
    logic [OUT_YW-1:0] map_y;

    always_ff @(posedge cclk or negedge rstb) begin
        if (!rstb) begin
            map_valid <= 1'b0;
            map_hi    <= 1'b0;
            map_lo    <= 1'b0;
            map_x     <= '0;
            map_y     <= '0;
        end else begin
            map_valid <= sample_valid;
            if (sample_valid) begin
                map_hi <= (touch_z >= ZP);
                map_lo <= (touch_z < ZR);
                map_x  <= map_x_d;
                map_y  <= map_y_d;
            end
        end
    end

    // ---------------- press FSM ----------------
    state_t        state, state_next;
    logic [DW-1:0] db_cnt, db_cnt_next;
    logic          pressed, pressed_next;

    always_ff @(posedge cclk or negedge rstb) begin
        if (!rstb) begin
            state  <= IDLE;
            db_cnt <= '0;
        end else begin
            state  <= state_next;
            db_cnt <= db_cnt_next;
        end
    end

    always_comb begin
        state_next  = state;
        db_cnt_next = db_cnt;
        if (map_valid) begin
            case (state)
                IDLE: if (map_hi) begin
                    state_next  = (DEBOUNCE == 1) ? PRESSED : PEND_PRESS;
                    db_cnt_next = (DEBOUNCE == 1) ? '0 : DW'(1);
                end
                PEND_PRESS: if (!map_hi) begin
                    state_next  = IDLE;
                    db_cnt_next = '0;
                end else if (db_cnt == DB_LAST) begin
                    state_next  = PRESSED;
                    db_cnt_next = '0;
                end else begin
                    db_cnt_next = db_cnt + DW'(1);
                end
                PRESSED: if (map_lo) begin
                    state_next  = (DEBOUNCE == 1) ? IDLE : PEND_REL;
                    db_cnt_next = (DEBOUNCE == 1) ? '0 : DW'(1);
                end
                PEND_REL: if (!map_lo) begin
                    state_next  = PRESSED;
                    db_cnt_next = '0;
                end else if (db_cnt == DB_LAST) begin
                    state_next  = IDLE;
                    db_cnt_next = '0;
                end else begin
                    db_cnt_next = db_cnt + DW'(1);
                end
                default: begin
                    state_next  = IDLE;
                    db_cnt_next = '0;
                end
            endcase
        end
    end

    assign pressed      = (state == PRESSED) || (state == PEND_REL);
    assign pressed_next = (state_next == PRESSED) || (state_next == PEND_REL);

    // ---------------- averaging ----------------
    logic [AXW-1:0]    acc_x, sum_x, avg_x;
    logic [AYW-1:0]    acc_y, sum_y, avg_y;
    logic [CW-1:0]     s_cnt;
    logic [OUT_XW-1:0] filt_x;
    logic [OUT_YW-1:0] filt_y;
    logic              filt_valid;

    always_comb begin
        sum_x = acc_x + AXW'(map_x);
        sum_y = acc_y + AYW'(map_y);
        avg_x = sum_x >> AVG_LOG2;
        avg_y = sum_y >> AVG_LOG2;
    end

    // The sample that completes the debounce is not averaged; the window starts fresh after it.
    always_ff @(posedge cclk or negedge rstb) begin
        if (!rstb) begin
            acc_x      <= '0;
            acc_y      <= '0;
            s_cnt      <= '0;
            filt_x     <= '0;
            filt_y     <= '0;
            filt_valid <= 1'b0;
        end else if (map_valid) begin
            if (pressed_next && !pressed) begin
                acc_x      <= '0;
                acc_y      <= '0;
                s_cnt      <= '0;
                filt_valid <= 1'b0;
            end else if (pressed) begin
                if (s_cnt == S_LAST) begin
                    acc_x      <= '0;
                    acc_y      <= '0;
                    s_cnt      <= '0;
                    filt_x     <= avg_x[OUT_XW-1:0];
                    filt_y     <= avg_y[OUT_YW-1:0];
                    filt_valid <= 1'b1;
                end else begin
                    acc_x <= sum_x;
                    acc_y <= sum_y;
                    s_cnt <= s_cnt + CW'(1);
                end
            end
        end
    end

    // ---------------- frame latch ----------------
    logic nf_q, frame_edge, active_new;

    assign frame_edge = new_frame && !nf_q;
    assign active_new = pressed && filt_valid;

    always_ff @(posedge cclk or negedge rstb) begin
        if (!rstb) begin
            nf_q          <= 1'b0;
            locked_x      <= '0;
            locked_y      <= '0;
            touch_active  <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            nf_q          <= new_frame;
            press_pulse   <= frame_edge && active_new && !touch_active;
            release_pulse <= frame_edge && !active_new && touch_active;
            if (frame_edge) begin
                touch_active <= active_new;
                if (active_new) begin
                    locked_x <= filt_x;
                    locked_y <= filt_y;
                end
            end
        end
    end

endmodule
